setpoint_controller: RTL and testbench

//  Parametrised setpoint entry and thermostat decision block for the patient-comfort controller.
//  - Debounces inc/dec buttons; while mode_switch=1, steps a saturating setpoint.
//  - Compares the setpoint with the sensor temperature and drives match/heat/cool outputs.
//  - Heat/cool use a hysteresis state machine. Sits between sensor front-end and actuator drivers.

---
 rtl/setpoint_controller_if.sv | 36 +++
 rtl/setpoint_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_setpoint_controller.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/setpoint_controller_if.sv
// setpoint_controller_if: operator/sensor-facing signal bundle of the setpoint controller.
//   master modport: environment side (drives mode/buttons/temperature, reads results)
//   slave modport : controller side
// Signals:
//   mode_switch   1 = set mode, setpoint editable
//   btn_inc       raw increment button (asynchronous)
//   btn_dec       raw decrement button (asynchronous)
//   current_temp  sensor temperature, synchronous to the controller clock
//   set_temp      registered setpoint
//   at_limit      setpoint sits at MIN_SET or MAX_SET
//   LED_match     current_temp equals set_temp
//   heat_on       thermostat in HEAT
//   cool_on       thermostat in COOL
interface setpoint_controller_if #(
    parameter int unsigned TEMP_W = 8
);
    logic              mode_switch;
    logic              btn_inc;
    logic              btn_dec;
    logic [TEMP_W-1:0] current_temp;
    logic [TEMP_W-1:0] set_temp;
    logic              at_limit;
    logic              LED_match;
    logic              heat_on;
    logic              cool_on;

    modport master (
        output mode_switch, btn_inc, btn_dec, current_temp,
        input  set_temp, at_limit, LED_match, heat_on, cool_on
    );

    modport slave (
        input  mode_switch, btn_inc, btn_dec, current_temp,
        output set_temp, at_limit, LED_match, heat_on, cool_on
    );
endinterface

// File: rtl/setpoint_controller.sv
// setpoint_controller: debounced setpoint entry plus hysteresis thermostat decision.
// Ports:
//   clk_i  single clock, all logic on posedge
//   rst_i  synchronous active-high reset
//   bus    setpoint_controller_if.slave (mode/buttons/temperature in, setpoint/flags out)
// Optional feature: define AUTO_REPEAT_EN to enable button auto-repeat (adds the
// REPEAT_DELAY / REPEAT_RATE parameters and the repeat counter).
module setpoint_controller #(
    parameter int unsigned TEMP_W    = 8,
    parameter int unsigned DB_CYCLES = 16'hFFFF,
    parameter int unsigned MIN_SET   = 16,
    parameter int unsigned MAX_SET   = 30,
    parameter int unsigned RESET_SET = 22,
    parameter int unsigned HYST      = 1
`ifdef AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = 24'd5000000,
    parameter int unsigned REPEAT_RATE  = 24'd2500000
`endif
) (
    input logic                 clk_i,
    input logic                 rst_i,
    setpoint_controller_if.slave bus
);

    localparam logic [15:0]       DbLast     = 16'(DB_CYCLES - 1);
    localparam logic [TEMP_W-1:0] MinSet     = TEMP_W'(MIN_SET);
    localparam logic [TEMP_W-1:0] MaxSet     = TEMP_W'(MAX_SET);
    localparam logic [TEMP_W-1:0] RstSet     = TEMP_W'(RESET_SET);
    localparam logic [TEMP_W:0]   Hyst       = (TEMP_W + 1)'(HYST);
    localparam logic              RstAtLimit = (RESET_SET == MIN_SET) || (RESET_SET == MAX_SET);

    typedef enum logic [1:0] {StIdle, StHeat, StCool} state_e;

    // Index 0 = inc button, index 1 = dec button.
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  level_q, level_d;
    logic [1:0]  level_prev_q;
    logic [1:0]  armed_q, armed_d;
    logic [1:0]  fill_q;
    logic [15:0] db_cnt_q [2];
    logic [15:0] db_cnt_d [2];
    logic [1:0]  pulse;
    logic [1:0]  step;

    logic [TEMP_W-1:0] set_q, set_d;
    logic              at_limit_q, at_limit_d;
    logic              led_match_q;
    logic              heat_on_q, cool_on_q;
    state_e            state_q;

    logic [TEMP_W:0] cur_x, set_x, set_hi, set_lo;

    // Debounce: counter runs only while the synced input disagrees with the level.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = 16'd0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 16'd1;
                end
            end
        end
        // A button still held through reset must be seen released (once the
        // synchroniser has refilled) before its next rising edge may step.
        armed_d = armed_q | ({2{fill_q[1]}} & ~sync2_q);
        pulse   = level_q & ~level_prev_q & armed_q;
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [23:0] RepDelay = 24'(REPEAT_DELAY);
    localparam logic [23:0] RepRate  = 24'(REPEAT_RATE);

    logic [23:0] rep_cnt_q, rep_cnt_d;
    logic        rep_run_q, rep_run_d;
    logic        rep_active;
    logic        rep_fire;

    // Exactly one armed button held in set mode keeps the repeat counter running.
    assign rep_active = (level_q[0] ^ level_q[1]) & bus.mode_switch & (|(level_q & armed_q));

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_run_d = rep_run_q;
        rep_fire  = 1'b0;
        if (!rep_active) begin
            rep_cnt_d = 24'd0;
            rep_run_d = 1'b0;
        end else if (|pulse) begin
            rep_cnt_d = 24'd1;
            rep_run_d = 1'b0;
        end else if ((!rep_run_q && rep_cnt_q == RepDelay) || (rep_run_q && rep_cnt_q == RepRate)) begin
            rep_fire  = 1'b1;
            rep_cnt_d = 24'd1;
            rep_run_d = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + 24'd1;
        end
        step = pulse | ({2{rep_fire}} & level_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rep_cnt_q <= 24'd0;
            rep_run_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_run_q <= rep_run_d;
        end
    end
`else
    assign step = pulse;
`endif

    // Setpoint: simultaneous inc+dec steps cancel.
    always_comb begin
        set_d = set_q;
        if (bus.mode_switch) begin
            case (step)
                2'b01: if (set_q < MaxSet) set_d = set_q + TEMP_W'(1);
                2'b10: if (set_q > MinSet) set_d = set_q - TEMP_W'(1);
                default: ;
            endcase
        end
        at_limit_d = (set_d == MinSet) || (set_d == MaxSet);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            level_q      <= 2'b00;
            level_prev_q <= 2'b00;
            armed_q      <= 2'b00;
            fill_q       <= 2'b00;
            db_cnt_q[0]  <= 16'd0;
            db_cnt_q[1]  <= 16'd0;
            set_q        <= RstSet;
            at_limit_q   <= RstAtLimit;
            led_match_q  <= 1'b0;
        end else begin
            sync1_q      <= {bus.btn_dec, bus.btn_inc};
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            armed_q      <= armed_d;
            fill_q       <= {fill_q[0], 1'b1};
            db_cnt_q[0]  <= db_cnt_d[0];
            db_cnt_q[1]  <= db_cnt_d[1];
            set_q        <= set_d;
            at_limit_q   <= at_limit_d;
            led_match_q  <= (bus.current_temp == set_q);
        end
    end

    // One extra bit so set+HYST cannot wrap; set-HYST clamps at zero.
    assign cur_x  = {1'b0, bus.current_temp};
    assign set_x  = {1'b0, set_q};
    assign set_hi = set_x + Hyst;
    assign set_lo = (set_x >= Hyst) ? (set_x - Hyst) : '0;

    // Thermostat FSM; heat/cool outputs are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            heat_on_q <= 1'b0;
            cool_on_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cur_x < set_lo) begin
                        state_q   <= StHeat;
                        heat_on_q <= 1'b1;
                        cool_on_q <= 1'b0;
                    end else if (cur_x > set_hi) begin
                        state_q   <= StCool;
                        heat_on_q <= 1'b0;
                        cool_on_q <= 1'b1;
                    end else begin
                        heat_on_q <= 1'b0;
                        cool_on_q <= 1'b0;
                    end
                end
                StHeat: begin
                    cool_on_q <= 1'b0;
                    if (cur_x >= set_x) begin
                        state_q   <= StIdle;
                        heat_on_q <= 1'b0;
                    end else begin
                        heat_on_q <= 1'b1;
                    end
                end
                StCool: begin
                    heat_on_q <= 1'b0;
                    if (cur_x <= set_x) begin
                        state_q   <= StIdle;
                        cool_on_q <= 1'b0;
                    end else begin
                        cool_on_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    heat_on_q <= 1'b0;
                    cool_on_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.set_temp  = set_q;
    assign bus.at_limit  = at_limit_q;
    assign bus.LED_match = led_match_q;
    assign bus.heat_on   = heat_on_q;
    assign bus.cool_on   = cool_on_q;

endmodule

// File: tb/tb_setpoint_controller.sv
// tb_setpoint_controller: self-checking bench for setpoint_controller with
// DB_CYCLES=4, MIN_SET=16, MAX_SET=30, RESET_SET=22, HYST=1
// (REPEAT_DELAY=8, REPEAT_RATE=4 when AUTO_REPEAT_EN is defined).
module tb_setpoint_controller;

    localparam int TW = 8;
`ifdef AUTO_REPEAT_EN
    localparam int HoldMax = 8;   // short enough that no repeat step can fire
`else
    localparam int HoldMax = 12;
`endif

    typedef struct {
        int cur;
        bit heat;
        bit cool;
        bit match;
    } tvec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    setpoint_controller_if #(.TEMP_W(TW)) bus_if ();

    setpoint_controller #(
        .TEMP_W      (TW),
        .DB_CYCLES   (4),
        .MIN_SET     (16),
        .MAX_SET     (30),
        .RESET_SET   (22),
`ifdef AUTO_REPEAT_EN
        .HYST        (1),
        .REPEAT_DELAY(8),
        .REPEAT_RATE (4)
`else
        .HYST        (1)
`endif
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    int m_set    = 22;
    int m_st     = 0;   // 0 idle, 1 heating, 2 cooling

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_set(input string name);
        chk({name, ".set_temp"}, 32'(bus_if.set_temp), m_set);
        chk({name, ".at_limit"}, 32'(bus_if.at_limit), (m_set == 16 || m_set == 30) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.btn_inc = 1'b0;
        bus_if.btn_dec = 1'b0;
        tick(2);
        rst = 1'b0;
        m_set = 22;
        tick(3);
    endtask

    // Hold buttons, release, then apply the model's view of that press.
    task automatic press(input bit inc, input bit dec, input int hold, input int rel);
        bus_if.btn_inc = inc;
        bus_if.btn_dec = dec;
        tick(hold);
        bus_if.btn_inc = 1'b0;
        bus_if.btn_dec = 1'b0;
        tick(rel);
        if (bus_if.mode_switch && (inc != dec)) begin
            if (inc) m_set = (m_set + 1 > 30) ? 30 : m_set + 1;
            else     m_set = (m_set - 1 < 16) ? 16 : m_set - 1;
        end
    endtask

    // Thermostat reference: hysteresis rules applied to the current setpoint.
    task automatic model_temp(input int c);
        int lo;
        int hi;
        lo = (m_set >= 1) ? m_set - 1 : 0;
        hi = m_set + 1;
        if (m_st == 0) begin
            if (c < lo)      m_st = 1;
            else if (c > hi) m_st = 2;
        end else if (m_st == 1) begin
            if (c >= m_set) m_st = 0;
        end else begin
            if (c <= m_set) m_st = 0;
        end
    endtask

    tvec_t tbl [13];
    int    nchg;
    int    first;
    int    prev;
    int    c;
`ifdef AUTO_REPEAT_EN
    int    chg_at [$];
    int    rep_off [5];
`endif

    initial begin
        tbl = '{
            '{20,  1, 0, 0}, '{21,  1, 0, 0}, '{22,  0, 0, 1}, '{23,  0, 0, 0},
            '{24,  0, 1, 0}, '{22,  0, 0, 1}, '{21,  0, 0, 0}, '{20,  1, 0, 0},
            '{25,  0, 0, 0}, '{25,  0, 1, 0}, '{0,   0, 0, 0}, '{0,   1, 0, 0},
            '{255, 0, 0, 0}
        };

        bus_if.mode_switch  = 1'b0;
        bus_if.btn_inc      = 1'b0;
        bus_if.btn_dec      = 1'b0;
        bus_if.current_temp = 8'd22;

        // Reset state, sampled while reset is held.
        tick(3);
        chk("rst.set_temp", 32'(bus_if.set_temp), 22);
        chk("rst.at_limit", 32'(bus_if.at_limit), 0);
        chk("rst.LED_match", 32'(bus_if.LED_match), 0);
        chk("rst.heat_on", 32'(bus_if.heat_on), 0);
        chk("rst.cool_on", 32'(bus_if.cool_on), 0);
        rst = 1'b0;
        tick(3);

        // One clean press: a single step within 8 cycles, none while held.
        bus_if.mode_switch = 1'b1;
        bus_if.btn_inc = 1'b1;
        nchg  = 0;
        first = -1;
        prev  = int'(bus_if.set_temp);
        for (int i = 1; i <= HoldMax + 8 - ((HoldMax == 8) ? 8 : 0); i++) begin
            tick(1);
            if (int'(bus_if.set_temp) != prev) begin
                nchg++;
                if (first < 0) first = i;
                prev = int'(bus_if.set_temp);
            end
        end
        bus_if.btn_inc = 1'b0;
        tick(10);
        m_set = 23;
        chk("press.steps", nchg, 1);
        chk("press.latency_ok", (first >= 1 && first <= 8) ? 1 : 0, 1);
        chk_set("press");

        // Bouncing input never settles long enough to step.
        for (int k = 0; k < 10; k++) begin
            bus_if.btn_inc = (k % 2 == 0);
            tick(2);
        end
        bus_if.btn_inc = 1'b0;
        tick(10);
        chk_set("bounce");

        // Saturation at both ends.
        do_reset();
        for (int k = 0; k < 10; k++) press(1'b0, 1'b1, 8, 8);
        chk_set("min_sat");
        for (int k = 0; k < 14; k++) press(1'b1, 1'b0, 8, 8);
        chk_set("max_reach");
        press(1'b1, 1'b0, 8, 8);
        chk_set("max_sat");

        // Mode 0 discards presses; simultaneous inc+dec cancels.
        do_reset();
        bus_if.mode_switch = 1'b0;
        press(1'b1, 1'b0, 8, 8);
        chk_set("mode0");
        bus_if.mode_switch = 1'b1;
        press(1'b1, 1'b1, 8, 8);
        chk_set("both");

        // Thermostat table at setpoint 22.
        for (int k = 0; k < 13; k++) begin
            bus_if.current_temp = 8'(tbl[k].cur);
            tick(1);
            chk($sformatf("tbl%0d.heat", k), 32'(bus_if.heat_on), 32'(tbl[k].heat));
            chk($sformatf("tbl%0d.cool", k), 32'(bus_if.cool_on), 32'(tbl[k].cool));
            chk($sformatf("tbl%0d.match", k), 32'(bus_if.LED_match), 32'(tbl[k].match));
        end
        bus_if.current_temp = 8'd22;
        tick(3);

        // Random presses, modes and short glitches.
        for (int k = 0; k < 40; k++) begin
            bus_if.mode_switch = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: press(1'b1, 1'b0, $urandom_range(7, HoldMax), $urandom_range(7, 10));
                1: press(1'b0, 1'b1, $urandom_range(7, HoldMax), $urandom_range(7, 10));
                2: press(1'b1, 1'b1, $urandom_range(7, HoldMax), $urandom_range(7, 10));
                default: begin
                    bus_if.btn_inc = 1'b1;
                    tick($urandom_range(1, 3));
                    bus_if.btn_inc = 1'b0;
                    tick(6);
                end
            endcase
            chk_set($sformatf("rnd%0d", k));
        end

        // Random temperatures around the current setpoint.
        bus_if.current_temp = 8'(m_set);
        tick(2);
        m_st = 0;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) == 0) c = $urandom_range(0, 255);
            else                           c = m_set + $urandom_range(0, 6) - 3;
            bus_if.current_temp = 8'(c);
            tick(1);
            model_temp(c);
            chk("rtemp.heat", 32'(bus_if.heat_on), (m_st == 1) ? 1 : 0);
            chk("rtemp.cool", 32'(bus_if.cool_on), (m_st == 2) ? 1 : 0);
            chk("rtemp.match", 32'(bus_if.LED_match), (c == m_set) ? 1 : 0);
        end
        bus_if.current_temp = 8'd22;

`ifdef AUTO_REPEAT_EN
        // Held press: steps at the edge, then +8, +12, +16, +20.
        rep_off = '{0, 8, 12, 16, 20};
        do_reset();
        tick(3);
        bus_if.mode_switch = 1'b1;
        bus_if.btn_inc = 1'b1;
        prev = int'(bus_if.set_temp);
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (int'(bus_if.set_temp) != prev) begin
                chg_at.push_back(i);
                prev = int'(bus_if.set_temp);
            end
        end
        chk("rep.count", chg_at.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < chg_at.size()) chk($sformatf("rep.off%0d", k), chg_at[k] - chg_at[0], rep_off[k]);
        end
        chk("rep.set", 32'(bus_if.set_temp), 27);
        // Reset while still held: back to 22 and no step until a fresh press.
        rst = 1'b1;
        tick(1);
        chk("rep.rst_set", 32'(bus_if.set_temp), 22);
        rst = 1'b0;
        tick(30);
        chk("rep.no_step", 32'(bus_if.set_temp), 22);
        bus_if.btn_inc = 1'b0;
        tick(10);
        m_set = 22;
        press(1'b1, 1'b0, 8, 10);
        chk_set("rep.new_press");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
